// File: rtl/alu_seq_if.sv
// Handshake and operand/result bundle for alu_seq.
// Holds the input valid/ready, operands and control, and the output valid/ready with result and flags.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic [3:0]       ALU_control;
    logic [2:0]       comp;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, src1, src2, ALU_control, comp, out_ready,
        input  in_ready, out_valid, result, zero, cout, overflow
    );

    modport slave (
        input  in_valid, src1, src2, ALU_control, comp, out_ready,
        output in_ready, out_valid, result, zero, cout, overflow
    );
endinterface

// File: rtl/alu_seq.sv
// Registered, handshaked WIDTH-bit ALU: logic ops, add/sub, set-on-compare, optional shift-add MUL.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier; otherwise code 1000 is treated as invalid.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    alu_seq_if.slave   bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SET = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_is_sub;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum_full;
    logic             w_add_ovf;
    logic             w_less;
    logic             w_eq;
    logic             w_cond;
    logic [WIDTH-1:0] w_res;
    logic             w_cout;
    logic             w_ovf;
    logic             w_in_ready;
    logic             w_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_cout;
    logic             r_ovf;

`ifdef ALU_SEQ_MUL_EN
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [3:0]  OP_MUL = 4'b1000;
    logic                   w_is_mul;
    logic [2*WIDTH-1:0]     r_acc;
    logic [2*WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [CW-1:0]          r_cnt;
    assign w_is_mul = (bus.ALU_control == OP_MUL);
`endif

    assign w_accept = bus.in_valid && w_in_ready;

    // Shared adder: SUB and SET use src1 + ~src2 + 1
    assign w_is_sub   = (bus.ALU_control == OP_SUB) || (bus.ALU_control == OP_SET);
    assign w_b        = w_is_sub ? ~bus.src2 : bus.src2;
    assign w_sum_full = {1'b0, bus.src1} + {1'b0, w_b} + (WIDTH+1)'(w_is_sub);
    assign w_add_ovf  = (bus.src1[WIDTH-1] == w_b[WIDTH-1]) &&
                        (w_sum_full[WIDTH-1] != bus.src1[WIDTH-1]);
    assign w_less     = w_sum_full[WIDTH-1] ^ w_add_ovf;
    assign w_eq       = (bus.src1 == bus.src2);

    always_comb begin
        w_cond = 1'b0;
        case (bus.comp)
            3'b000:  w_cond = w_less;
            3'b001:  w_cond = !w_less && !w_eq;
            3'b010:  w_cond = w_less || w_eq;
            3'b011:  w_cond = !w_less;
            3'b100:  w_cond = w_eq;
            3'b101:  w_cond = !w_eq;
            default: w_cond = 1'b0;
        endcase
    end

    // Single-cycle result and flags for the non-MUL codes
    always_comb begin
        w_res  = '0;
        w_cout = 1'b0;
        w_ovf  = 1'b0;
        case (bus.ALU_control)
            OP_AND: w_res = bus.src1 & bus.src2;
            OP_OR:  w_res = bus.src1 | bus.src2;
            OP_NOR: w_res = ~(bus.src1 | bus.src2);
            OP_ADD, OP_SUB: begin
                w_res  = w_sum_full[WIDTH-1:0];
                w_cout = w_sum_full[WIDTH];
                w_ovf  = w_add_ovf;
            end
            OP_SET: w_res = WIDTH'(w_cond);
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef ALU_SEQ_MUL_EN
                    w_state_nxt = w_is_mul ? S_MUL : S_DONE;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
`ifdef ALU_SEQ_MUL_EN
            S_MUL:  if (r_cnt == '0) w_state_nxt = S_DONE;
`endif
            S_DONE: if (bus.out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE:  w_in_ready  = 1'b1;
            S_DONE:  w_out_valid = 1'b1;
            default: ;
        endcase
    end

    // Result/flag registers and, when built, the shift-add multiplier
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
`endif
        end else if (w_accept) begin
`ifdef ALU_SEQ_MUL_EN
            if (w_is_mul) begin
                r_acc    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, bus.src1};
                r_mplier <= bus.src2;
                r_cnt    <= CW'(WIDTH);
            end else
`endif
            begin
                r_result <= w_res;
                r_zero   <= (w_res == '0);
                r_cout   <= w_cout;
                r_ovf    <= w_ovf;
            end
        end
`ifdef ALU_SEQ_MUL_EN
        else if (r_state == S_MUL) begin
            if (r_cnt == '0) begin
                r_result <= r_acc[WIDTH-1:0];
                r_zero   <= (r_acc[WIDTH-1:0] == '0);
                r_cout   <= 1'b0;
                r_ovf    <= |r_acc[2*WIDTH-1:WIDTH];
            end else begin
                if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - CW'(1);
            end
        end
`endif
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.cout      = r_cout;
    assign bus.overflow  = r_ovf;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised WIDTH-bit registered ALU with a valid/ready handshake on its input and output sides.
- Performs AND, OR, NOR, ADD, SUB and the set-on-compare family (less / greater / le / ge / eq / ne, selected by comp), with signed overflow, carry and zero flags.
- Optionally performs an iterative unsigned shift-add multiply.
- Sits between the CPU decode/control stage and writeback, replacing the ripple slice array with a single parametrised, handshaked unit.

Parameters:
- WIDTH, 32, operand and result width in bits (>= 4).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and control are valid this cycle.
- in_ready  output  1  unit can accept an operation this cycle.
- src1  input  WIDTH  operand A.
- src2  input  WIDTH  operand B.
- ALU_control  input  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SET, 1100 NOR, 1000 MUL (optional); other codes are invalid.
- comp  input  3  SET condition: 000 lt, 001 gt, 010 le, 011 ge, 100 eq, 101 ne; 110/111 give 0.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result this cycle.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- cout  output  1  carry out of the MSB (ADD/SUB only).
- overflow  output  1  signed overflow (ADD/SUB), or high half nonzero (MUL).

Behaviour:
- Reset (async, rst_i=0):
  - State goes to IDLE.
  - in_ready=1 once reset is released; out_valid=0.
  - result=0, zero=1, cout=0, overflow=0.
  - Multiplier registers are cleared.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - MUL: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept rule: an operation is accepted when in_valid && in_ready. Operands and control are captured on that edge; later input changes are ignored.
- IDLE transitions on accept:
  - Non-MUL operation: compute and register the result and flags, then go to DONE. out_valid rises on the next cycle (1-cycle latency).
  - MUL: load the multiplicand, the multiplier and a counter = WIDTH, then go to MUL.
- MUL state:
  - Each cycle: if multiplier[0], add the multiplicand into the 2*WIDTH accumulator.
  - Each cycle: shift the multiplicand left and the multiplier right, and decrement the counter.
  - When the counter reaches 0, register result = acc[WIDTH-1:0] and overflow = |acc[2W-1:W], with cout=0, then go to DONE.
  - out_valid is asserted exactly WIDTH+1 cycles after the accept edge.
- DONE state:
  - result and flags are held stable while out_ready=0.
  - When out_ready=1, go to IDLE; the next accept is possible one cycle later.
  - There is no same-cycle accept in DONE: one operation outstanding at a time.
- Arithmetic:
  - SUB computes src1 + ~src2 + 1.
  - cout is the raw carry out of the MSB; for SUB, cout=1 means no borrow.
  - overflow = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the inverted operand for SUB.
- SET family:
  - Internal subtract: less = sum_msb ^ ovf (signed); equal = (src1 == src2).
  - result = {(WIDTH-1)'b0, cond}.
  - cout=0 and overflow=0.
- Logic ops: cout=0, overflow=0.
- zero is always derived from the registered result.
- Invalid ALU_control: result=0, flags 0 (zero=1), 1-cycle latency, normal handshake.
- Reset mid-MUL or mid-DONE: the operation is aborted, outputs return to their reset values and no out_valid pulse is produced.
- Edge cases: ADD wraps modulo 2^WIDTH; MUL by 0 still takes the full WIDTH cycles.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: MUL (1000) is implemented as described above.
- Undefined: the MUL state, accumulator and counter are not built; code 1000 is treated as an invalid control code (result 0, 1-cycle latency).

Test Plan:
- Reset: hold rst_i=0 for 3 cycles, then release -> in_ready=1, out_valid=0, result=0, zero=1, cout=0, overflow=0.
- ADD overflow: ADD 0x7FFFFFFF + 0x00000001 -> one cycle after accept, out_valid=1, result=0x80000000, overflow=1, cout=0, zero=0.
- SUB with carry: SUB 5 - 5 -> result=0, zero=1, cout=1, overflow=0.
- SET signed compare: SET comp=000 with src1=0xFFFFFFFF (-1), src2=1 -> result=1. The same operands with comp=001 -> result=0.
- Backpressure: ADD 3+4 with out_ready=0 for 5 cycles -> result=7 is held stable, in_ready=0 throughout; on out_ready=1, in_ready=1 next cycle.
- MUL (ALU_SEQ_MUL_EN defined):
  - 0x00010000 * 0x00010000 -> out_valid at accept+33, result=0, overflow=1.
  - 6*7 -> result=42, overflow=0.
  - Reset asserted at cycle 10 of a MUL -> no out_valid, reset outputs.
